// File: rtl/vproc_div_issue.sv
// Issue/retire wrapper for one divider lane: extends SEW operands for the fixed-latency
// div block, tracks results with a non-stalling valid/tag pipe and buffers them in order.
module vproc_div_issue #(
  parameter int unsigned DIV_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4
) (
  input  logic             clk_i,
  input  logic             async_rst_ni,
  input  logic             sync_rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_signed_i,
  input  logic             req_mod_i,
  input  logic [1:0]       req_sew_i,
  input  logic [31:0]      req_op1_i,
  input  logic [31:0]      req_op2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             div_mod_o,
  output logic [32:0]      div_op1_o,
  output logic [32:0]      div_op2_o,
  input  logic [31:0]      div_res_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic             busy_o
);

  localparam int unsigned   PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned   CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  function automatic logic [32:0] ext33(input logic [31:0] op, input logic [1:0] sew,
                                        input logic sgn);
    logic [32:0] r;
    case (sew)
      2'b00:   r = {{25{sgn & op[7]}}, op[7:0]};
      2'b01:   r = {{17{sgn & op[15]}}, op[15:0]};
      default: r = {sgn & op[31], op};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mask_sew(input logic [31:0] val, input logic [1:0] sew);
    logic [31:0] r;
    case (sew)
      2'b00:   r = {24'd0, val[7:0]};
      2'b01:   r = {16'd0, val[15:0]};
      default: r = val;
    endcase
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  logic [CW-1:0]    r_occ;
  logic [32:0]      r_op1;
  logic [32:0]      r_op2;
  logic             r_mod;
  logic [DIV_LAT:0] r_pv;
  logic [1:0]       r_psew [0:DIV_LAT];
  logic [TAG_W-1:0] r_ptag [0:DIV_LAT];
  logic [31:0]      r_mem_data [0:FIFO_DEPTH-1];
  logic [TAG_W-1:0] r_mem_tag  [0:FIFO_DEPTH-1];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_pop;
  logic             w_push;
  logic [31:0]      w_push_data;

  // Ready comes from registered occupancy only, which also counts in-flight elements.
  assign req_ready_o = (r_occ < FULL_CNT);
  assign busy_o      = (r_occ != {CW{1'b0}});
  assign res_valid_o = (r_cnt != {CW{1'b0}});
  assign res_data_o  = r_mem_data[r_rd_ptr];
  assign res_tag_o   = r_mem_tag[r_rd_ptr];
  assign div_op1_o   = r_op1;
  assign div_op2_o   = r_op2;
  assign div_mod_o   = r_mod;

  assign w_accept    = req_valid_i & req_ready_o;
  assign w_pop       = res_valid_o & res_ready_i;
  assign w_push      = r_pv[DIV_LAT];
  assign w_push_data = mask_sew(div_res_i, r_psew[DIV_LAT]);

  // Stage I register plus the fixed valid/sew/tag shift that mirrors the div block latency.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_op1 <= 33'd0;
      r_op2 <= 33'd0;
      r_mod <= 1'b0;
      for (int k = 0; k <= int'(DIV_LAT); k++) begin
        r_pv[k]   <= 1'b0;
        r_psew[k] <= 2'd0;
        r_ptag[k] <= {TAG_W{1'b0}};
      end
    end else if (!sync_rst_ni) begin
      r_op1 <= 33'd0;
      r_op2 <= 33'd0;
      r_mod <= 1'b0;
      for (int k = 0; k <= int'(DIV_LAT); k++) begin
        r_pv[k]   <= 1'b0;
        r_psew[k] <= 2'd0;
        r_ptag[k] <= {TAG_W{1'b0}};
      end
    end else begin
      r_pv[0] <= w_accept;
      if (w_accept) begin
        r_op1     <= ext33(req_op1_i, req_sew_i, req_signed_i);
        r_op2     <= ext33(req_op2_i, req_sew_i, req_signed_i);
        r_mod     <= req_mod_i;
        r_psew[0] <= req_sew_i;
        r_ptag[0] <= req_tag_i;
      end
      for (int k = 1; k <= int'(DIV_LAT); k++) begin
        r_pv[k]   <= r_pv[k-1];
        r_psew[k] <= r_psew[k-1];
        r_ptag[k] <= r_ptag[k-1];
      end
    end
  end

  // Occupancy: accepted minus popped elements.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_occ <= {CW{1'b0}};
    end else if (!sync_rst_ni) begin
      r_occ <= {CW{1'b0}};
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // In-order result FIFO; cannot overflow because occupancy bounds the in-flight count.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_cnt    <= {CW{1'b0}};
      for (int k = 0; k < int'(FIFO_DEPTH); k++) begin
        r_mem_data[k] <= 32'd0;
        r_mem_tag[k]  <= {TAG_W{1'b0}};
      end
    end else if (!sync_rst_ni) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_cnt    <= {CW{1'b0}};
      for (int k = 0; k < int'(FIFO_DEPTH); k++) begin
        r_mem_data[k] <= 32'd0;
        r_mem_tag[k]  <= {TAG_W{1'b0}};
      end
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_push_data;
        r_mem_tag[r_wr_ptr]  <= r_ptag[DIV_LAT];
        r_wr_ptr             <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_vproc_div_issue.sv
// Bench for vproc_div_issue: a registered div-block stand-in, a directed vector table,
// corner-case sequences and randomized traffic checked against a queue-based reference.
module tb_vproc_div_issue;
  localparam int DL = 1;
  localparam int FD = 4;
  localparam int TW = 4;

  logic          clk_i = 1'b0;
  logic          async_rst_ni = 1'b1;
  logic          sync_rst_ni = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_signed_i = 1'b0;
  logic          req_mod_i = 1'b0;
  logic [1:0]    req_sew_i = 2'd0;
  logic [31:0]   req_op1_i = 32'd0;
  logic [31:0]   req_op2_i = 32'd0;
  logic [TW-1:0] req_tag_i = '0;
  logic          div_mod_o;
  logic [32:0]   div_op1_o;
  logic [32:0]   div_op2_o;
  logic [31:0]   div_res_i = 32'd0;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;
  logic [31:0]   res_data_o;
  logic [TW-1:0] res_tag_o;
  logic          busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct { logic [TW-1:0] tag; logic [31:0] data; int t; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic sgn; logic md; logic [1:0] sew;
    logic [31:0] op1; logic [31:0] op2; logic [31:0] exp;
  } vec_t;
  vec_t vecs[16];

  vproc_div_issue #(.DIV_LAT(DL), .FIFO_DEPTH(FD), .TAG_W(TW)) dut (
    .clk_i(clk_i), .async_rst_ni(async_rst_ni), .sync_rst_ni(sync_rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_signed_i(req_signed_i),
    .req_mod_i(req_mod_i), .req_sew_i(req_sew_i), .req_op1_i(req_op1_i),
    .req_op2_i(req_op2_i), .req_tag_i(req_tag_i), .div_mod_o(div_mod_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .div_res_i(div_res_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_tag_o(res_tag_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in for the div block: 33-bit signed divide, one register stage (DL = 1).
  function automatic logic [31:0] blk(input logic [32:0] x, input logic [32:0] y, input logic md);
    longint a, b, r;
    a = longint'($signed(x));
    b = longint'($signed(y));
    if (b == 0) r = md ? a : -1;
    else        r = md ? (a % b) : (a / b);
    return r[31:0];
  endfunction

  always @(posedge clk_i) div_res_i <= blk(div_op1_o, div_op2_o, div_mod_o);

  // Reference: element-level RISC-V divide semantics at the selected SEW.
  function automatic logic [31:0] ref_res(input logic sgn, input logic md, input logic [1:0] sew,
                                          input logic [31:0] op1, input logic [31:0] op2);
    int w;
    longint m, a, b, q, r;
    w = (sew == 2'd0) ? 8 : (sew == 2'd1) ? 16 : 32;
    m = (longint'(1) << w) - 1;
    a = longint'(op1) & m;
    b = longint'(op2) & m;
    if (sgn && a[w-1]) a = a - (longint'(1) << w);
    if (sgn && b[w-1]) b = b - (longint'(1) << w);
    if (b == 0) begin
      q = m; r = a;
    end else if (sgn && b == -1 && a == -(longint'(1) << (w - 1))) begin
      q = a; r = 0;
    end else begin
      q = a / b; r = a % b;
    end
    return 32'((md ? r : q) & m);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Check the cycle against the model, update the model, advance one clock.
  task automatic step();
    logic ev;
    exp_t e;
    ev = 1'b0;
    if (sb.size() > 0) ev = (sb[0].t + DL + 2 <= cyc);
    chk("res_valid", 32'(res_valid_o), 32'(ev));
    chk("req_ready", 32'(req_ready_o), 32'(sb.size() < FD));
    chk("busy", 32'(busy_o), 32'(sb.size() != 0));
    if (!sync_rst_ni) begin
      sb.delete();
    end else begin
      if (res_valid_o && res_ready_i) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL pop_unexpected: got data %h with no element outstanding (cycle %0d)",
                   res_data_o, cyc);
        end else begin
          e = sb.pop_front();
          chk("res_data", res_data_o, e.data);
          chk("res_tag", 32'(res_tag_o), 32'(e.tag));
        end
      end
      if (req_valid_i && req_ready_o) begin
        e.tag  = req_tag_i;
        e.data = ref_res(req_signed_i, req_mod_i, req_sew_i, req_op1_i, req_op2_i);
        e.t    = cyc;
        sb.push_back(e);
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic rand_req();
    req_signed_i = 1'($urandom_range(0, 1));
    req_mod_i    = 1'($urandom_range(0, 1));
    req_sew_i    = 2'($urandom_range(0, 3));
    req_op1_i    = $urandom;
    case ($urandom_range(0, 7))
      0:       req_op2_i = 32'd0;
      1:       req_op2_i = 32'hFFFF_FFFF;
      2:       req_op2_i = 32'($urandom_range(1, 9));
      default: req_op2_i = $urandom;
    endcase
    if ($urandom_range(0, 5) == 0) begin
      if (req_sew_i == 2'd0)      req_op1_i = {req_op1_i[31:8], 8'h80};
      else if (req_sew_i == 2'd1) req_op1_i = {req_op1_i[31:16], 16'h8000};
      else                        req_op1_i = 32'h8000_0000;
    end
  endtask

  task automatic drain(input int bound);
    req_valid_i = 1'b0;
    res_ready_i = 1'b1;
    for (int k = 0; k < bound && sb.size() > 0; k++) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, pops, t0, start;
    logic got;

    vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 32'h00000080,   32'h000000FF, 32'h00000080};
    vecs[2]  = '{1'b1, 1'b1, 2'd0, 32'h00000080,   32'h000000FF, 32'h00000000};
    vecs[3]  = '{1'b0, 1'b0, 2'd2, 32'hFFFFFFFF,   32'h00000002, 32'h7FFFFFFF};
    vecs[4]  = '{1'b0, 1'b0, 2'd1, 32'h00001234,   32'h00000000, 32'h0000FFFF};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 32'h00001234,   32'h00000000, 32'h00001234};
    vecs[6]  = '{1'b1, 1'b0, 2'd1, 32'h00008000,   32'h0000FFFF, 32'h00008000};
    vecs[7]  = '{1'b1, 1'b1, 2'd1, 32'h00008000,   32'h0000FFFF, 32'h00000000};
    vecs[8]  = '{1'b1, 1'b0, 2'd2, 32'h80000000,   32'hFFFFFFFF, 32'h80000000};
    vecs[9]  = '{1'b1, 1'b1, 2'd2, 32'h80000000,   32'hFFFFFFFF, 32'h00000000};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 32'h000000F3,   32'h00000000, 32'h000000FF};
    vecs[11] = '{1'b1, 1'b1, 2'd0, 32'h000000F3,   32'h00000000, 32'h000000F3};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 32'hABCD00C8,   32'h12345607, 32'h0000001C};
    vecs[13] = '{1'b0, 1'b1, 2'd0, 32'hABCD00C8,   32'h12345607, 32'h00000004};
    vecs[14] = '{1'b0, 1'b0, 2'd3, 32'h00000064,   32'h0000000A, 32'h0000000A};
    vecs[15] = '{1'b1, 1'b1, 2'd1, 32'h0000FFF9,   32'h00000002, 32'h0000FFFF};

    #1 async_rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_res_valid", 32'(res_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_res_data", res_data_o, 32'd0);
    chk("rst_res_tag", 32'(res_tag_o), 32'd0);
    chk("rst_div_op1", div_op1_o[31:0], 32'd0);
    chk("rst_div_op2", div_op2_o[31:0], 32'd0);
    chk("rst_div_mod", 32'(div_mod_o), 32'd0);
    async_rst_ni = 1'b1;
    step();

    // Directed vectors, one at a time, with exact-latency check.
    for (int i = 0; i < 16; i++) begin
      req_signed_i = vecs[i].sgn; req_mod_i = vecs[i].md; req_sew_i = vecs[i].sew;
      req_op1_i = vecs[i].op1; req_op2_i = vecs[i].op2; req_tag_i = TW'(i);
      req_valid_i = 1'b1; res_ready_i = 1'b1;
      t0 = cyc;
      step();
      req_valid_i = 1'b0;
      got = 1'b0;
      for (int w = 0; w < 12 && !got; w++) begin
        if (res_valid_o) begin
          got = 1'b1;
          chk("vec_latency", 32'(cyc - t0), 32'(DL + 2));
          chk($sformatf("vec%0d_data", i), res_data_o, vecs[i].exp);
          chk($sformatf("vec%0d_tag", i), 32'(res_tag_o), 32'(i));
        end
        step();
      end
      if (!got) begin
        n_checks++; n_fail++;
        $display("FAIL vec%0d_timeout: got no result expected one within 12 cycles", i);
      end
    end

    // Backpressure: exactly FD accepts, then ready low; drain in order.
    res_ready_i = 1'b0; req_valid_i = 1'b1; acc = 0;
    for (int k = 0; k < FD + 3; k++) begin
      rand_req();
      req_tag_i = TW'(acc);
      if (req_ready_o) acc++;
      step();
    end
    chk("fill_accepts", 32'(acc), 32'(FD));
    chk("fill_ready_low", 32'(req_ready_o), 32'd0);
    req_valid_i = 1'b0; res_ready_i = 1'b1; pops = 0;
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      if (res_valid_o) pops++;
      step();
    end
    chk("drain_pops", 32'(pops), 32'(FD));
    repeat (4) step();

    // Throughput: 32 back-to-back requests with the consumer always ready.
    res_ready_i = 1'b1; acc = 0; pops = 0; start = cyc;
    while (acc < 32 && cyc - start < 100) begin
      rand_req();
      req_tag_i = TW'(acc);
      req_valid_i = 1'b1;
      if (req_ready_o) acc++;
      if (res_valid_o) pops++;
      step();
    end
    chk("tput_cycles", 32'(cyc - start), 32'd32);
    chk("tput_pops", 32'(pops), 32'(32 - (DL + 2)));
    drain(20);

    // Asynchronous reset with three elements in flight.
    res_ready_i = 1'b0; req_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_req(); req_tag_i = TW'(k); step();
    end
    req_valid_i = 1'b0;
    step();
    #2 async_rst_ni = 1'b0;
    #1 sb.delete();
    chk("arst_res_valid", 32'(res_valid_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk_i);
    cyc++;
    res_ready_i = 1'b1;
    step();
    async_rst_ni = 1'b1;
    repeat (8) step();

    // Synchronous reset with two elements in flight.
    res_ready_i = 1'b0; req_valid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rand_req(); req_tag_i = TW'(k + 5); step();
    end
    req_valid_i = 1'b0; sync_rst_ni = 1'b0;
    step();
    sync_rst_ni = 1'b1; res_ready_i = 1'b1;
    repeat (8) step();

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 500; k++) begin
      rand_req();
      req_tag_i   = TW'($urandom);
      req_valid_i = ($urandom_range(0, 9) < 7);
      res_ready_i = ($urandom_range(0, 9) < 6);
      step();
    end
    drain(40);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
